// File: rtl/riscv_isa_pkg.sv
// Shared core package (riscv_isa).
// Provides the register-file geometry defaults, the RESULT record carried
// by every execution-unit result channel, and a scan-order helper used by
// the result arbiter.
package riscv_isa;

    localparam int RF_AWIDTH = 7;
    localparam int RF_DWIDTH = 32;

    // One execution-unit result: destination register plus data.
    typedef struct packed {
        logic [RF_AWIDTH-1:0] rd;
        logic [RF_DWIDTH-1:0] data;
    } result_t;

    localparam int RESULT_W = $bits(result_t);

    // Position of channel idx in a round-robin scan that starts at ptr.
    function automatic int scan_pos(input int idx, input int ptr, input int n);
        return (idx >= ptr) ? (idx - ptr) : (idx + n - ptr);
    endfunction

endpackage

// File: rtl/result_arbiter_rr_select.sv
// rr_select: round-robin selector.
// Scans req from ptr upward (mod N) and hands out up to W grants, one
// one-hot vector per grant slot, in scan order.
// Ports:
//   req       [N]    eligible requests
//   ptr       [PW]   scan start
//   sel       [W*N]  slot k grant vector at sel[k*N +: N]
//   sel_valid [W]    slot k carries a grant
//   next_ptr  [PW]   one past the last granted channel, or ptr if none
module rr_select #(
    parameter int N  = 3,
    parameter int W  = 2,
    parameter int PW = 2
) (
    input  logic [N-1:0]   req,
    input  logic [PW-1:0]  ptr,
    output logic [W*N-1:0] sel,
    output logic [W-1:0]   sel_valid,
    output logic [PW-1:0]  next_ptr
);

    always_comb begin
        int   cnt;
        int   idx;
        int   last;
        logic any;
        sel       = '0;
        sel_valid = '0;
        cnt       = 0;
        idx       = 0;
        last      = 0;
        any       = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = int'(ptr) + k;
            if (idx >= N) idx = idx - N;
            if (req[idx] && (cnt < W)) begin
                sel[cnt*N + idx] = 1'b1;
                sel_valid[cnt]   = 1'b1;
                cnt              = cnt + 1;
                any              = 1'b1;
                last             = idx;
            end
        end
        if (any) next_ptr = (last + 1 >= N) ? '0 : PW'(last + 1);
        else     next_ptr = ptr;
    end

endmodule

// File: rtl/result_arbiter.sv
// result_arbiter: merges N execution-unit result channels onto W
// register-file write ports with round-robin fairness.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   result [N*(A+D)]        channel i = {rd, data} at bit i*(A+D)
//   result_valid/ready [N]  per-channel handshake (ready is combinational)
//   write_addr/data/valid   registered regbank write ports (W)
// Optional feature, macro RESULT_ARB_BYPASS_EN: adds byp_valid/byp_addr/
// byp_data, the current-cycle writes for operand forwarding.
// rd == 0 results are accepted and dropped; they use a grant slot (keeps the
// round-robin fair) but no write port.
module result_arbiter
    import riscv_isa::*;
#(
    parameter int N      = 3,
    parameter int W      = 2,
    parameter int DWIDTH = RF_DWIDTH,
    parameter int AWIDTH = RF_AWIDTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N*(AWIDTH+DWIDTH)-1:0] result,
    input  logic [N-1:0]               result_valid,
    output logic [N-1:0]               result_ready,
    output logic [W*AWIDTH-1:0]        write_addr,
    output logic [W*DWIDTH-1:0]        write_data,
    output logic [W-1:0]               write_valid
`ifdef RESULT_ARB_BYPASS_EN
    ,
    output logic [W-1:0]               byp_valid,
    output logic [W*AWIDTH-1:0]        byp_addr,
    output logic [W*DWIDTH-1:0]        byp_data
`endif
);

    localparam int RW = AWIDTH + DWIDTH;
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     next_ptr;
    logic [AWIDTH-1:0] ch_rd   [N];
    logic [DWIDTH-1:0] ch_data [N];
    logic [N-1:0]      req;
    logic [W*N-1:0]    sel;
    logic [W-1:0]      sel_valid;
    logic [W-1:0]      nxt_valid;
    logic [W*AWIDTH-1:0] nxt_addr;
    logic [W*DWIDTH-1:0] nxt_data;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            ch_rd[i]   = result[i*RW + DWIDTH +: AWIDTH];
            ch_data[i] = result[i*RW +: DWIDTH];
        end
    end

    // A channel is held back when an earlier channel in scan order is valid
    // with the same nonzero rd, so same-register writes land in scan order.
    always_comb begin
        logic blocked;
        req = '0;
        for (int i = 0; i < N; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < N; j++) begin
                if ((j != i) && result_valid[j] && (ch_rd[i] != '0) &&
                    (ch_rd[j] == ch_rd[i]) &&
                    (scan_pos(j, int'(ptr), N) < scan_pos(i, int'(ptr), N)))
                    blocked = 1'b1;
            end
            req[i] = result_valid[i] && !blocked && !reset;
        end
    end

    rr_select #(.N(N), .W(W), .PW(PW)) u_rr_select (
        .req       (req),
        .ptr       (ptr),
        .sel       (sel),
        .sel_valid (sel_valid),
        .next_ptr  (next_ptr)
    );

    // Grant slots are in scan order; writing grants are packed onto ports
    // 0.. in that same order, discards are skipped.
    always_comb begin
        int port;
        result_ready = '0;
        nxt_valid    = '0;
        nxt_addr     = '0;
        nxt_data     = '0;
        port         = 0;
        for (int k = 0; k < W; k++) begin
            for (int c = 0; c < N; c++) begin
                if (sel_valid[k] && sel[k*N + c]) begin
                    result_ready[c] = 1'b1;
                    if ((ch_rd[c] != '0) && (port < W)) begin
                        nxt_valid[port]                 = 1'b1;
                        nxt_addr[port*AWIDTH +: AWIDTH] = ch_rd[c];
                        nxt_data[port*DWIDTH +: DWIDTH] = ch_data[c];
                        port = port + 1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr         <= '0;
            write_valid <= '0;
            write_addr  <= '0;
            write_data  <= '0;
        end else begin
            ptr         <= next_ptr;
            write_valid <= nxt_valid;
            write_addr  <= nxt_addr;
            write_data  <= nxt_data;
        end
    end

`ifdef RESULT_ARB_BYPASS_EN
    assign byp_valid = nxt_valid;
    assign byp_addr  = nxt_addr;
    assign byp_data  = nxt_data;
`endif

endmodule

// File: tb/tb_result_arbiter.sv
module tb_result_arbiter;
    import riscv_isa::*;

    localparam int N = 3;
    localparam int W = 2;
    localparam int A = RF_AWIDTH;
    localparam int D = RF_DWIDTH;

    logic               clk = 1'b0;
    logic               reset;
    logic [N*(A+D)-1:0] result;
    logic [N-1:0]       result_valid;
    logic [N-1:0]       result_ready;
    logic [W*A-1:0]     write_addr;
    logic [W*D-1:0]     write_data;
    logic [W-1:0]       write_valid;
`ifdef RESULT_ARB_BYPASS_EN
    logic [W-1:0]       byp_valid;
    logic [W*A-1:0]     byp_addr;
    logic [W*D-1:0]     byp_data;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    result_arbiter #(.N(N), .W(W), .DWIDTH(D), .AWIDTH(A)) dut (
        .clk          (clk),
        .reset        (reset),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .write_valid  (write_valid)
`ifdef RESULT_ARB_BYPASS_EN
        ,
        .byp_valid    (byp_valid),
        .byp_addr     (byp_addr),
        .byp_data     (byp_data)
`endif
    );

    typedef struct {
        logic           rst;
        logic [2:0]     valid;
        logic [A-1:0]   rd0, rd1, rd2;
        logic [D-1:0]   d0, d1, d2;
        logic [2:0]     exp_ready;
        logic [1:0]     exp_wv;
        logic [2*A-1:0] exp_waddr;  // {port1, port0}
        logic [2*D-1:0] exp_wdata;  // {port1, port0}
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst, input logic [2:0] v,
                         input logic [A-1:0] r0, input logic [D-1:0] x0,
                         input logic [A-1:0] r1, input logic [D-1:0] x1,
                         input logic [A-1:0] r2, input logic [D-1:0] x2);
        result_t c0, c1, c2;
        c0 = '{rd: r0, data: x0};
        c1 = '{rd: r1, data: x1};
        c2 = '{rd: r2, data: x2};
        reset        = rst;
        result_valid = v;
        result       = {c2, c1, c0};
    endtask

    function automatic vec_t mk(input logic rst, input logic [2:0] v,
            input logic [A-1:0] r0, input logic [D-1:0] x0,
            input logic [A-1:0] r1, input logic [D-1:0] x1,
            input logic [A-1:0] r2, input logic [D-1:0] x2,
            input logic [2:0] er, input logic [1:0] ewv,
            input logic [A-1:0] a1, input logic [A-1:0] a0,
            input logic [D-1:0] w1, input logic [D-1:0] w0);
        vec_t t;
        t.rst = rst; t.valid = v;
        t.rd0 = r0; t.rd1 = r1; t.rd2 = r2;
        t.d0 = x0; t.d1 = x1; t.d2 = x2;
        t.exp_ready = er; t.exp_wv = ewv;
        t.exp_waddr = {a1, a0};
        t.exp_wdata = {w1, w0};
        return t;
    endfunction

    initial begin
        int wait_c[N];
        logic [2:0] fv;

        //              rst valid  rd0 d0       rd1 d1            rd2 d2      ready wv   a1  a0  w1      w0
        vecs[0]  = mk(1, 3'b111, 5, 'h11,  6, 'h12,          7, 'h13,  3'b000, 2'b00, 0,  0,  'h0,  'h0);
        vecs[1]  = mk(0, 3'b111, 5, 'hA0,  6, 'hA1,          7, 'hA2,  3'b011, 2'b11, 6,  5,  'hA1, 'hA0);
        vecs[2]  = mk(0, 3'b100, 0, 'h0,   0, 'h0,           7, 'hA2,  3'b100, 2'b01, 0,  7,  'h0,  'hA2);
        vecs[3]  = mk(0, 3'b101, 9, 'hB0,  0, 'h0,           9, 'hB2,  3'b001, 2'b01, 0,  9,  'h0,  'hB0);
        vecs[4]  = mk(0, 3'b100, 0, 'h0,   0, 'h0,           9, 'hB2,  3'b100, 2'b01, 0,  9,  'h0,  'hB2);
        vecs[5]  = mk(0, 3'b010, 0, 'h0,   0, 'hDEADBEEF,    0, 'h0,   3'b010, 2'b00, 0,  0,  'h0,  'h0);
        vecs[6]  = mk(0, 3'b111, 1, 'hC0,  2, 'hC1,          3, 'hC2,  3'b101, 2'b11, 1,  3,  'hC0, 'hC2);
        vecs[7]  = mk(0, 3'b111, 0, 'hD0,  4, 'hD1,          4, 'hD2,  3'b011, 2'b01, 0,  4,  'h0,  'hD1);
        vecs[8]  = mk(0, 3'b111, 8, 'hE0, 10, 'hE1,         11, 'hE2,  3'b110, 2'b11, 11, 10, 'hE2, 'hE1);
        vecs[9]  = mk(0, 3'b000, 8, 'hE0, 10, 'hE1,         11, 'hE2,  3'b000, 2'b00, 0,  0,  'h0,  'h0);
        vecs[10] = mk(0, 3'b110, 3, 'hF0, 12, 'hF1,         13, 'hF2,  3'b110, 2'b11, 13, 12, 'hF2, 'hF1);

        drive(1, 3'b000, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);

        for (int v = 0; v < 11; v++) begin
            @(negedge clk);
            drive(vecs[v].rst, vecs[v].valid, vecs[v].rd0, vecs[v].d0,
                  vecs[v].rd1, vecs[v].d1, vecs[v].rd2, vecs[v].d2);
            #1;
            chk($sformatf("v%0d ready", v), 64'(result_ready), 64'(vecs[v].exp_ready));
            @(posedge clk); #1;
            chk($sformatf("v%0d write_valid", v), 64'(write_valid), 64'(vecs[v].exp_wv));
            chk($sformatf("v%0d write_addr", v),  64'(write_addr),  64'(vecs[v].exp_waddr));
            chk($sformatf("v%0d write_data", v),  64'(write_data),  64'(vecs[v].exp_wdata));
        end

        // Reset the cycle after a grant: pending write is visible, then dropped; ptr back to 0.
        @(negedge clk);
        drive(0, 3'b111, 5, 'h50, 6, 'h60, 7, 'h70);
        #1 chk("rst_seq ready pre", 64'(result_ready), 64'(3'b011));
        @(negedge clk);
        chk("rst_seq write_valid pre", 64'(write_valid), 64'(2'b11));
        drive(1, 3'b111, 5, 'h50, 6, 'h60, 7, 'h70);
        #1 chk("rst_seq ready in reset", 64'(result_ready), 64'(3'b000));
        @(posedge clk); #1;
        chk("rst_seq write_valid after", 64'(write_valid), 64'(2'b00));
        chk("rst_seq write_addr after",  64'(write_addr),  64'(0));
        chk("rst_seq write_data after",  64'(write_data),  64'(0));
        @(negedge clk);
        drive(0, 3'b111, 5, 'h50, 6, 'h60, 7, 'h70);
        #1 chk("rst_seq ready resume (ptr 0)", 64'(result_ready), 64'(3'b011));
        @(posedge clk); #1;
        chk("rst_seq write_addr resume", 64'(write_addr), 64'({7'd6, 7'd5}));
        chk("rst_seq write_data resume", 64'(write_data), 64'({32'h60, 32'h50}));

        // Fairness: ch0 always valid, ch1/ch2 come and go; nobody waits past 2 cycles.
        for (int c = 0; c < N; c++) wait_c[c] = 0;
        fv = 3'b001;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            fv[0] = 1'b1;
            for (int c = 1; c < N; c++)
                if (!fv[c]) fv[c] = 1'($urandom_range(0, 1));
            drive(0, fv, 1, 32'(cyc), 2, 32'(cyc), 3, 32'(cyc));
            #1;
            for (int c = 0; c < N; c++) begin
                if (fv[c]) begin
                    wait_c[c]++;
                    n_cmp++;
                    if (wait_c[c] > 2) begin
                        n_bad++;
                        $display("FAIL fair ch%0d: waited %0d cycles, max 2", c, wait_c[c]);
                    end
                    if (result_ready[c]) begin
                        wait_c[c] = 0;
                        if (c != 0) fv[c] = 1'b0;
                    end
                end
            end
        end

`ifdef RESULT_ARB_BYPASS_EN
        @(negedge clk);
        drive(0, 3'b010, 0, 0, 12, 32'h42, 0, 0);
        #1;
        chk("byp_valid", 64'(byp_valid[0]), 64'(1));
        chk("byp_addr",  64'(byp_addr[A-1:0]), 64'(12));
        chk("byp_data",  64'(byp_data[D-1:0]), 64'(32'h42));
        @(posedge clk); #1;
        chk("byp write_addr", 64'(write_addr[A-1:0]), 64'(12));
`endif

        @(negedge clk);
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/result_arbiter.md
RESULT_ARBITER -- requirements
Module: result_arbiter

Interface
REQ-001 SHALL have parameter N, default 3, number of execution-unit result channels (N >= 1).
REQ-002 SHALL have parameter W, default 2, number of register-file write ports (1 <= W <= N).
REQ-003 SHALL have parameter DWIDTH, default 32, result data width.
REQ-004 SHALL have parameter AWIDTH, default 7, physical register address width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state rising-edge.
REQ-006 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-007 SHALL have port result, input, N x RESULT, per channel {rd[AWIDTH], data[DWIDTH]}.
REQ-008 SHALL have port result_valid, input, N, per-channel result present.
REQ-009 SHALL have port result_ready, output, N, per-channel result consumed this cycle.
REQ-010 SHALL have port write_addr, output, W x AWIDTH, regbank write address per port.
REQ-011 SHALL have port write_data, output, W x DWIDTH, regbank write data per port.
REQ-012 SHALL have port write_valid, output, W, write-port enable.

Function
REQ-013 SHALL transfer channel i when result_valid[i] and result_ready[i] are both high in the same cycle.
REQ-014 SHALL derive result_ready combinationally from result_valid, result.rd and arbiter state; no combinational dependence on outputs.
REQ-015 SHALL grant at most W channels per cycle, scanning from round-robin pointer ptr upward modulo N.
REQ-016 SHALL advance ptr to (last granted channel index + 1) mod N after any grant; ptr holds when nothing is granted.
REQ-017 SHALL accept a result with rd == 0 as a discard: result_ready high, no write port consumed, no write issued.
REQ-018 SHALL, when two valid channels carry the same nonzero rd in one cycle, grant only the first in scan order and stall the other.
REQ-019 SHALL assign granted channels to write ports 0..W-1 in scan order; unused ports have write_valid 0.
REQ-020 SHALL register write_addr/write_data/write_valid: latency exactly 1 cycle from handshake to write.
REQ-021 SHALL drive write_addr and write_data to 0 on any port whose write_valid is 0.
REQ-022 SHALL guarantee a channel held valid is granted within ceil(N/W) cycles.

Reset
REQ-023 SHALL, while reset is high, force result_ready = 0, write_valid = 0, write_addr = 0, write_data = 0, ptr = 0.
REQ-024 SHALL drop any result in the output register when reset asserts mid-operation; no write appears on the cycle after reset.

Configuration
REQ-025 SHALL, with RESULT_ARB_BYPASS_EN defined, add outputs byp_valid[W], byp_addr[W x AWIDTH], byp_data[W x DWIDTH] carrying the current-cycle grants combinationally, for operand forwarding.
REQ-026 SHALL, without RESULT_ARB_BYPASS_EN, omit the bypass ports entirely; all other behaviour is identical.

Structure
REQ-027 SHALL take the RESULT typedef and AWIDTH/DWIDTH defaults from the shared core package (riscv_isa).
REQ-028 SHALL place round-robin selection in sub-module rr_select (N requests, ptr in, up to W one-hot grants out).

Verification
REQ-029 N=3,W=2: all valid, rd=5,6,7, ptr=0 -> ready=011, next cycle ports 0/1 write 5/6; then ch2 (rd 7) granted and written.
REQ-030 Ch0 and ch2 both rd=9, ptr=0 -> only ch0 ready; ch2 granted the following cycle; regbank sees two writes to 9 in order.
REQ-031 Ch1 valid with rd=0, data=0xDEADBEEF -> ready high, write_valid stays 0 on all ports.
REQ-032 Ch0 held valid continuously, ch1/ch2 toggling for 20 cycles -> every valid channel waits at most 2 cycles.
REQ-033 Reset asserted the cycle after a grant -> write_valid 0 the next cycle, ptr 0, then normal operation resumes.
REQ-034 Bypass build, ch1 rd=12 data=0x00000042 -> byp_valid[0]=1, byp_addr=12, byp_data=0x42 same cycle; write one cycle later.
